// File: rtl/dcf77_pulse_decoder.sv
// DCF77 pulse-width decoder: classifies low pulses into bits, locks onto the
// minute marker, assembles and checks the 59-bit frame, and outputs BCD minute/hour.
module dcf77_pulse_decoder #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned T_MIN_PULSE  = 50,
  parameter int unsigned T_THRESH     = 150,
  parameter int unsigned T_MAX_PULSE  = 250,
  parameter int unsigned T_PERIOD_MIN = 900,
  parameter int unsigned T_GAP_MIN    = 1500,
  parameter int unsigned T_TIMEOUT    = 2500
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        sgn_in,
  output logic        sync_out,
  output logic        bit_out,
  output logic        bit_valid_out,
  output logic [5:0]  sec_out,
  output logic        frame_valid_out,
  output logic [58:0] frame_out,
  output logic [6:0]  minute_out,
  output logic [5:0]  hour_out,
  output logic        err_out
);

  localparam logic [CNT_W-1:0] MinPulse  = CNT_W'(T_MIN_PULSE);
  localparam logic [CNT_W-1:0] Thresh    = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MaxPulse  = CNT_W'(T_MAX_PULSE);
  localparam logic [CNT_W-1:0] PeriodMin = CNT_W'(T_PERIOD_MIN);
  localparam logic [CNT_W-1:0] GapMin    = CNT_W'(T_GAP_MIN);
  localparam logic [CNT_W-1:0] Timeout   = CNT_W'(T_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StHunt, StLow, StHigh} state_e;

  logic             s1_q, s2_q, s3_q;
  logic             fall, rise;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  state_e           state_q;
  logic [5:0]       bit_cnt_q;
  logic [58:0]      shreg_q;
  logic             frame_ok;

  logic             sync_q, bit_q, bit_valid_q, frame_valid_q, err_q;
  logic [5:0]       sec_q;
  logic [58:0]      frame_q;
  logic [6:0]       minute_q;
  logic [5:0]       hour_q;

  assign fall = ~s2_q & s3_q;
  assign rise = s2_q & ~s3_q;

  always_comb begin
    period_cnt_d = period_cnt_q;
    low_cnt_d    = low_cnt_q;
    if (fall) begin
      period_cnt_d = '0;
      low_cnt_d    = '0;
    end else begin
      if (period_cnt_q != CntMax) period_cnt_d = period_cnt_q + CntOne;
      if (!s2_q && low_cnt_q != CntMax) low_cnt_d = low_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s3_q         <= 1'b1;
      period_cnt_q <= '0;
      low_cnt_q    <= '0;
    end else begin
      s1_q         <= sgn_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      period_cnt_q <= period_cnt_d;
      low_cnt_q    <= low_cnt_d;
    end
  end

  // Even parity over each of the three protected fields.
  assign frame_ok = (bit_cnt_q == 6'd59) && !shreg_q[0] && shreg_q[20] &&
                    !(^shreg_q[28:21]) && !(^shreg_q[35:29]) && !(^shreg_q[58:36]);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q       <= StHunt;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      sync_q        <= 1'b0;
      bit_q         <= 1'b0;
      bit_valid_q   <= 1'b0;
      sec_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_q       <= '0;
      minute_q      <= '0;
      hour_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      bit_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (fall && period_cnt_q >= GapMin) begin
            bit_cnt_q <= '0;
            sync_q    <= 1'b1;
            state_q   <= StLow;
          end
        end
        StLow: begin
          if ((!s2_q && low_cnt_q > MaxPulse) || (rise && low_cnt_q < MinPulse)) begin
            err_q     <= 1'b1;
            sync_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= StHunt;
          end else if (rise) begin
            shreg_q[bit_cnt_q] <= (low_cnt_q >= Thresh);
            bit_q              <= (low_cnt_q >= Thresh);
            sec_q              <= bit_cnt_q;
            bit_valid_q        <= 1'b1;
            bit_cnt_q          <= bit_cnt_q + 6'd1;
            state_q            <= StHigh;
          end
        end
        StHigh: begin
          // Timeout takes precedence over a coincident edge.
          if ((period_cnt_q > Timeout) ||
              (fall && period_cnt_q < PeriodMin) ||
              (fall && period_cnt_q < GapMin && bit_cnt_q >= 6'd59) ||
              (fall && period_cnt_q >= GapMin && !frame_ok)) begin
            err_q     <= 1'b1;
            sync_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= StHunt;
          end else if (fall && period_cnt_q < GapMin) begin
            state_q <= StLow;
          end else if (fall) begin
            frame_q       <= shreg_q;
            minute_q      <= shreg_q[27:21];
            hour_q        <= shreg_q[34:29];
            frame_valid_q <= 1'b1;
            bit_cnt_q     <= '0;
            state_q       <= StLow;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign sync_out        = sync_q;
  assign bit_out         = bit_q;
  assign bit_valid_out   = bit_valid_q;
  assign sec_out         = sec_q;
  assign frame_valid_out = frame_valid_q;
  assign frame_out       = frame_q;
  assign minute_out      = minute_q;
  assign hour_out        = hour_q;
  assign err_out         = err_q;

endmodule
